// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the master and slave read/write blocks.
package axi4_lite_pkg;

    typedef logic [1:0] t_axi_resp;

    localparam t_axi_resp RESP_OKAY   = 2'b00;
    localparam t_axi_resp RESP_EXOKAY = 2'b01;
    localparam t_axi_resp RESP_SLVERR = 2'b10;
    localparam t_axi_resp RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_slave_read_if.sv
// AXI4-Lite read address/data channels between a read master and a read slave.
interface axi4_lite_slave_read_if
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);

    logic              AR_VALID;
    logic              AR_READY;
    logic [ADDR_W-1:0] AR_ADDR;
    logic [2:0]        AR_PROT;
    logic              R_VALID;
    logic              R_READY;
    logic [DATA_W-1:0] R_DATA;
    t_axi_resp         R_RESP;

    modport master (
        output AR_VALID, AR_ADDR, AR_PROT, R_READY,
        input  AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AR_VALID, AR_ADDR, AR_PROT, R_READY,
        output AR_READY, R_VALID, R_DATA, R_RESP
    );

endinterface

// File: rtl/axi4_lite_slave_read.sv
// AXI4-Lite read responder: one outstanding AR, one word fetched from a fixed-latency
// backing memory, returned on R with OKAY/SLVERR/DECERR.
//
// state    | meaning
// IDLE     | AR_READY high, waiting for a read request
// MEM_WAIT | memory strobed, counting down the read latency
// RESP     | R_VALID high, holding data/response until R_READY
module axi4_lite_slave_read
    import axi4_lite_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 64,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        MEM_LATENCY    = 1
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    axi4_lite_slave_read_if.slave         bus,
    output logic                          mem_rd_o,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr_o,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_data_i
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LSB   = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH) << LSB;
    localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK  = AXI_ADDR_WIDTH'((AXI_DATA_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        RESP
    } t_slv_rd_state;

    t_slv_rd_state               state_q, state_d;
    logic                        ar_ready_q, ar_ready_d;
    logic                        r_valid_q, r_valid_d;
    logic [AXI_DATA_WIDTH-1:0]   r_data_q, r_data_d;
    t_axi_resp                   r_resp_q, r_resp_d;
    logic                        mem_rd_q, mem_rd_d;
    logic [IDX_W-1:0]            mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [AXI_ADDR_WIDTH-1:0]   offset;
    logic                        below_base;
    logic                        dec_err;
    logic                        slv_err;
    logic [IDX_W-1:0]            word_idx;

    // AR_PROT carries no meaning for this responder.
    logic                        unused_prot;
    assign unused_prot = ^bus.AR_PROT;

    // Borrow of the subtraction flags addresses below the window without a constant compare.
    always_comb begin
        {below_base, offset} = {1'b0, bus.AR_ADDR} - {1'b0, BASE_ADDR};
        dec_err  = below_base || (offset >= MEM_BYTES);
        slv_err  = |(offset & LSB_MASK);
        word_idx = offset[LSB +: IDX_W];
    end

    always_comb begin
        state_d    = state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                ar_ready_d = 1'b1;
                if (bus.AR_VALID && ar_ready_q) begin
                    ar_ready_d = 1'b0;
                    if (dec_err) begin
                        r_valid_d = 1'b1;
                        r_data_d  = '0;
                        r_resp_d  = RESP_DECERR;
                        state_d   = RESP;
                    end else if (slv_err) begin
                        r_valid_d = 1'b1;
                        r_data_d  = '0;
                        r_resp_d  = RESP_SLVERR;
                        state_d   = RESP;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = word_idx;
                        cnt_d      = CNT_W'(MEM_LATENCY);
                        state_d    = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) begin
                    r_valid_d = 1'b1;
                    r_data_d  = mem_data_i;
                    r_resp_d  = RESP_OKAY;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.R_READY) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                ar_ready_d = 1'b0;
                r_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.AR_READY = ar_ready_q;
    assign bus.R_VALID  = r_valid_q;
    assign bus.R_DATA   = r_data_q;
    assign bus.R_RESP   = r_resp_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = mem_addr_q;

endmodule
